// File: rtl/ram_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_ctrl
// Description : Sole initiator of a single-port no-change block RAM.
//               Captures one frame from a write stream starting at address 0,
//               then replays it as a backpressured read stream. RAM read
//               latency is tracked with a valid shift register. A 4-entry
//               prefetch FIFO absorbs that latency, and a credit check keeps
//               returning data from ever overflowing it.
// Options     : RAM_STREAM_CTRL_DROP_CNT_EN adds drop_cnt, a saturating count
//               of s_valid cycles seen outside WRITE.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_ctrl #(
   parameter int RAM_WIDTH    = 18,
   parameter int ADDR_W       = 10,
   parameter int READ_LATENCY = 2
) (
   input  logic                 clka,
   input  logic                 rsta_n,
   input  logic                 wr_start,
   input  logic                 rd_start,
   input  logic [ADDR_W:0]      frame_len,
   input  logic [RAM_WIDTH-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 full,
`ifdef RAM_STREAM_CTRL_DROP_CNT_EN
   output logic [15:0]          drop_cnt,
`endif
   output logic [ADDR_W-1:0]    ram_addra,
   output logic [RAM_WIDTH-1:0] ram_dina,
   output logic                 ram_wea,
   output logic                 ram_ena,
   output logic                 ram_regcea,
   output logic                 ram_rsta,
   input  logic [RAM_WIDTH-1:0] ram_douta
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_FULL  = 3'd2,
      ST_READ  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] c_ptr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   c_len_one = {{ADDR_W{1'b0}}, 1'b1};

   state_t                r_state;
   logic [ADDR_W:0]       r_len;
   logic [ADDR_W-1:0]     r_wr_ptr;
   logic [ADDR_W-1:0]     r_rd_ptr;
   logic                  r_busy;
   logic                  r_full;
   logic [READ_LATENCY-1:0] r_vld_sr;
   logic [2:0]            r_inflight;
   logic [2:0]            r_fifo_cnt;
   logic [1:0]            r_fifo_wr_idx;
   logic [1:0]            r_fifo_rd_idx;
   logic [RAM_WIDTH-1:0]  r_fifo_mem [0:3];

   logic [ADDR_W:0]       w_len_m1;
   logic                  w_wr_beat;
   logic                  w_wr_last;
   logic                  w_credit;
   logic                  w_rd_issue;
   logic                  w_rd_last;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_start_ok;
   logic [2:0]            w_fifo_cnt_nxt;
   logic [2:0]            w_inflight_nxt;

   assign w_len_m1   = r_len - c_len_one;
   assign w_start_ok = wr_start && (frame_len != '0);
   assign w_wr_beat  = (r_state == ST_WRITE) && s_valid;
   assign w_wr_last  = ({1'b0, r_wr_ptr} == w_len_m1);
   // Outstanding reads plus buffered words never exceed the FIFO depth.
   assign w_credit   = ({1'b0, r_fifo_cnt} + {1'b0, r_inflight}) < 4'd4;
   assign w_rd_issue = (r_state == ST_READ) && w_credit;
   assign w_rd_last  = ({1'b0, r_rd_ptr} == w_len_m1);
   assign w_push     = r_vld_sr[READ_LATENCY-1];
   assign w_pop      = m_valid && m_ready;

   assign w_fifo_cnt_nxt = r_fifo_cnt + {2'b00, w_push} - {2'b00, w_pop};
   assign w_inflight_nxt = r_inflight + {2'b00, w_rd_issue} - {2'b00, w_push};

   assign s_ready    = (r_state == ST_WRITE);
   assign busy       = r_busy;
   assign full       = r_full;
   assign m_valid    = (r_fifo_cnt != 3'd0);
   assign m_data     = r_fifo_mem[r_fifo_rd_idx];

   assign ram_ena    = w_wr_beat || w_rd_issue;
   assign ram_wea    = w_wr_beat;
   assign ram_addra  = w_wr_beat ? r_wr_ptr : (w_rd_issue ? r_rd_ptr : '0);
   assign ram_dina   = w_wr_beat ? s_data : '0;
   assign ram_regcea = 1'b1;
   assign ram_rsta   = 1'b0;

   // Frame sequencing: capture, hold, replay, then wait for the pipeline to empty.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         r_state  <= ST_IDLE;
         r_len    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_busy   <= 1'b0;
         r_full   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_ok) begin
                  r_len    <= frame_len;
                  r_wr_ptr <= '0;
                  r_rd_ptr <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (w_wr_beat) begin
                  r_wr_ptr <= r_wr_ptr + c_ptr_one;
                  if (w_wr_last) begin
                     r_full  <= 1'b1;
                     r_state <= ST_FULL;
                  end
               end
            end
            ST_FULL: begin
               if (rd_start) begin
                  r_rd_ptr <= '0;
                  r_full   <= 1'b0;
                  r_state  <= ST_READ;
               end
            end
            ST_READ: begin
               if (w_rd_issue) begin
                  r_rd_ptr <= r_rd_ptr + c_ptr_one;
                  if (w_rd_last) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Leave as soon as the final pop empties everything.
               if ((r_inflight == 3'd0) && (w_fifo_cnt_nxt == 3'd0)) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_full  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_sr_lat1
         // Single-stage return marker.
         always_ff @(posedge clka or negedge rsta_n) begin
            if (!rsta_n) r_vld_sr <= '0;
            else         r_vld_sr <= w_rd_issue;
         end
      end else begin : g_sr_latn
         // Multi-stage return marker tracking the RAM output pipeline.
         always_ff @(posedge clka or negedge rsta_n) begin
            if (!rsta_n) r_vld_sr <= '0;
            else         r_vld_sr <= {r_vld_sr[READ_LATENCY-2:0], w_rd_issue};
         end
      end
   endgenerate

   // Prefetch FIFO and in-flight accounting.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         r_inflight    <= '0;
         r_fifo_cnt    <= '0;
         r_fifo_wr_idx <= '0;
         r_fifo_rd_idx <= '0;
         for (int i = 0; i < 4; i++) r_fifo_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_fifo_mem[r_fifo_wr_idx] <= ram_douta;
            r_fifo_wr_idx             <= r_fifo_wr_idx + 2'd1;
         end
         if (w_pop) begin
            r_fifo_rd_idx <= r_fifo_rd_idx + 2'd1;
         end
         r_fifo_cnt <= w_fifo_cnt_nxt;
         r_inflight <= w_inflight_nxt;
      end
   end

`ifdef RAM_STREAM_CTRL_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   // Count write-stream beats offered while no frame capture is running.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         r_drop_cnt <= '0;
      end else if ((r_state == ST_IDLE) && w_start_ok) begin
         r_drop_cnt <= '0;
      end else if (s_valid && (r_state != ST_WRITE) && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`else
   // Stray s_valid outside WRITE is simply never acknowledged.
`endif

endmodule
`default_nettype wire
